jtag_user_dr: RTL

User data register that hangs off the TAP outputs of the AHB JTAG debug link and drives `tapi_tdo` back into it. It brings the TAP control strobes into the system clock domain and implements a DR_WIDTH-bit capture/shift/update register, selected when the TAP holds USER_INST. Completed update words are handed to system logic over a valid/ready port, with sticky overflow reporting. It sits directly downstream of the JTAG TAP in the `*_random` out-of-context top levels.

---
 rtl/jtag_user_dr.sv | 122 ++++++++++++
 1 files changed

// File: rtl/jtag_user_dr.sv
// rtl/jtag_user_dr.sv - JTAG user data register bridged into the system clock domain
module jtag_user_dr #(
   parameter int          DR_WIDTH    = 32,
   parameter logic [7:0]  USER_INST   = 8'h02,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tapo_tck,
   input  logic                tapo_tdi,
   input  logic [7:0]          tapo_inst,
   input  logic                tapo_rst,
   input  logic                tapo_capt,
   input  logic                tapo_shft,
   input  logic                tapo_upd,
   output logic                tapi_tdo,
   input  logic [DR_WIDTH-1:0] cap_data,
   output logic [DR_WIDTH-1:0] upd_data,
   output logic                upd_valid,
   input  logic                upd_ready,
   output logic                overflow,
   input  logic                overflow_clr
);

   // Bit positions of the TAP signals inside each synchronizer stage.
   localparam int B_TCK  = 0;
   localparam int B_TDI  = 1;
   localparam int B_RST  = 2;
   localparam int B_CAPT = 3;
   localparam int B_SHFT = 4;
   localparam int B_UPD  = 5;

   logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
   logic [5:0]                  tap_s;
   logic [7:0]                  inst_q, inst_d;
   logic                        tck_prev_q, tck_prev_d;
   logic                        evt_q, evt_d;
   logic [DR_WIDTH-1:0]         sr_q, sr_d;
   logic                        tdo_q, tdo_d;
   logic [DR_WIDTH-1:0]         upd_data_q, upd_data_d;
   logic                        upd_valid_q, upd_valid_d;
   logic                        overflow_q, overflow_d;
   logic                        sel;
   logic                        ovf_set;

   assign tap_s = sync_q[SYNC_STAGES-1];
   assign sel   = (inst_q == USER_INST);

   // Synchronizer chains for every TAP signal except the quasi-static instruction.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {tapo_upd, tapo_shft, tapo_capt, tapo_rst, tapo_tdi, tapo_tck};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      inst_d     = tapo_inst;
      tck_prev_d = tap_s[B_TCK];
      evt_d      = tap_s[B_TCK] & ~tck_prev_q;
   end

   // Data register, update port handshake and sticky overflow.
   always_comb begin
      sr_d        = sr_q;
      upd_data_d  = upd_data_q;
      upd_valid_d = upd_valid_q;
      ovf_set     = 1'b0;
      if (upd_valid_q && upd_ready) begin
         upd_valid_d = 1'b0;
      end
      if (tap_s[B_RST]) begin
         // TAP test-logic reset clears only the shift path, never the handed-off word.
         sr_d = '0;
      end else if (evt_q && sel) begin
         if (tap_s[B_CAPT]) begin
            sr_d = cap_data;
         end else if (tap_s[B_SHFT]) begin
            sr_d = {tap_s[B_TDI], sr_q[DR_WIDTH-1:1]};
         end else if (tap_s[B_UPD]) begin
            if (!upd_valid_q || upd_ready) begin
               upd_data_d  = sr_q;
               upd_valid_d = 1'b1;
            end else begin
               ovf_set = 1'b1;
            end
         end
      end
      // A new drop in the same cycle as a clear must remain visible.
      overflow_d = ovf_set | (overflow_q & ~overflow_clr);
      tdo_d      = sel & sr_d[0];
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q      <= '0;
         inst_q      <= '0;
         tck_prev_q  <= 1'b0;
         evt_q       <= 1'b0;
         sr_q        <= '0;
         tdo_q       <= 1'b0;
         upd_data_q  <= '0;
         upd_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         inst_q      <= inst_d;
         tck_prev_q  <= tck_prev_d;
         evt_q       <= evt_d;
         sr_q        <= sr_d;
         tdo_q       <= tdo_d;
         upd_data_q  <= upd_data_d;
         upd_valid_q <= upd_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign tapi_tdo  = tdo_q;
   assign upd_data  = upd_data_q;
   assign upd_valid = upd_valid_q;
   assign overflow  = overflow_q;

endmodule
